// File: rtl/rx_frame_mem_arbiter.sv
// Four-lane write-buffered frame memory arbiter: per-lane FIFOs drain round-robin into one
// memory port, shared with a read path that wins unless some lane FIFO is full.
module rx_frame_mem_arbiter #(
  parameter int ADD_W      = 17,
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [3:0]          WrReq,
  input  logic [3:0]          WrSelC,
  input  logic [4*ADD_W-1:0]  WrAdd,
  input  logic [4*DATA_W-1:0] WrData,
  input  logic                RdReq,
  input  logic [1:0]          RdLane,
  input  logic                RdSelC,
  input  logic [ADD_W-1:0]    RdAdd,
  output logic                RdGnt,
  output logic                RdValid,
  output logic [DATA_W-1:0]   RdData,
  output logic                MemEn,
  output logic                MemWe,
  output logic [1:0]          MemLane,
  output logic                MemSelC,
  output logic [ADD_W-1:0]    MemAdd,
  output logic [DATA_W-1:0]   MemWData,
  input  logic [DATA_W-1:0]   MemRData,
  input  logic                OvfClr,
  output logic [3:0]          Overflow,
  output logic [11:0]         FifoLevel
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int         ENT_W   = 1 + ADD_W + DATA_W;
  localparam logic [2:0] DEPTH_L = 3'(FIFO_DEPTH);

  logic              run_reg;
  logic [1:0]        rr_ptr_reg;
  logic [3:0]        full, nonempty, pop, push, drop;
  logic [ENT_W-1:0]  head [4];
  logic              rd_gnt, wr_gnt, wr_found;
  logic [1:0]        wr_sel, cand;
  logic [ENT_W-1:0]  wr_head;
  logic              rd_issue_reg, rd_valid_reg;
  logic [3:0]        ovf_reg, ovf_next;
  logic              mem_en_reg, mem_we_reg, mem_selc_reg;
  logic [1:0]        mem_lane_reg;
  logic [ADD_W-1:0]  mem_add_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [2:0]       count_reg;

      assign full[gi]     = (count_reg == DEPTH_L);
      assign nonempty[gi] = (count_reg != 3'd0);
      // A full lane still accepts a beat when its head leaves in the same cycle.
      assign push[gi]     = WrReq[gi] & (~full[gi] | pop[gi]);
      assign drop[gi]     = WrReq[gi] & full[gi] & ~pop[gi];
      assign head[gi]     = mem_reg[rd_ptr_reg];
      assign FifoLevel[gi*3 +: 3] = count_reg;

      always_ff @(posedge clk) begin
        if (push[gi])
          mem_reg[wr_ptr_reg] <= {WrSelC[gi], WrAdd[gi*ADD_W +: ADD_W], WrData[gi*DATA_W +: DATA_W]};
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (push[gi] && !pop[gi])      count_reg <= count_reg + 3'd1;
          else if (pop[gi] && !push[gi]) count_reg <= count_reg - 3'd1;
        end
      end
    end
  endgenerate

  // run_reg holds off grants for one cycle after reset release.
  always_comb begin
    rd_gnt   = run_reg & RdReq & ~(|full);
    wr_found = 1'b0;
    wr_sel   = rr_ptr_reg;
    cand     = rr_ptr_reg;
    for (int off = 0; off < 4; off++) begin
      cand = rr_ptr_reg + 2'(off);
      if (!wr_found && nonempty[cand]) begin
        wr_found = 1'b1;
        wr_sel   = cand;
      end
    end
    wr_gnt = run_reg & ~rd_gnt & wr_found;
    pop    = 4'd0;
    if (wr_gnt) pop[wr_sel] = 1'b1;
    wr_head = head[wr_sel];
  end

  assign ovf_next = (OvfClr ? 4'd0 : ovf_reg) | drop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_reg       <= 1'b0;
      rr_ptr_reg    <= 2'd0;
      rd_issue_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      ovf_reg       <= 4'd0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_lane_reg  <= 2'd0;
      mem_selc_reg  <= 1'b0;
      mem_add_reg   <= '0;
      mem_wdata_reg <= '0;
    end else begin
      run_reg      <= 1'b1;
      rd_issue_reg <= rd_gnt;
      rd_valid_reg <= rd_issue_reg;
      ovf_reg      <= ovf_next;
      if (rd_gnt) begin
        mem_en_reg   <= 1'b1;
        mem_we_reg   <= 1'b0;
        mem_lane_reg <= RdLane;
        mem_selc_reg <= RdSelC;
        mem_add_reg  <= RdAdd;
      end else if (wr_gnt) begin
        mem_en_reg   <= 1'b1;
        mem_we_reg   <= 1'b1;
        mem_lane_reg <= wr_sel;
        {mem_selc_reg, mem_add_reg, mem_wdata_reg} <= wr_head;
        rr_ptr_reg   <= wr_sel + 2'd1;
      end else begin
        mem_en_reg <= 1'b0;
        mem_we_reg <= 1'b0;
      end
    end
  end

  assign RdGnt    = rd_gnt;
  assign RdValid  = rd_valid_reg;
  assign RdData   = rd_valid_reg ? MemRData : '0;
  assign Overflow = ovf_reg;
  assign MemEn    = mem_en_reg;
  assign MemWe    = mem_we_reg;
  assign MemLane  = mem_lane_reg;
  assign MemSelC  = mem_selc_reg;
  assign MemAdd   = mem_add_reg;
  assign MemWData = mem_wdata_reg;

endmodule

// File: tb/tb_rx_frame_mem_arbiter.sv
// Bench for rx_frame_mem_arbiter: queue-based lane model plus synchronous memory model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_rx_frame_mem_arbiter;
  localparam int AW = 17, DW = 5, DEPTH = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] WrReq = '0, WrSelC = '0;
  logic [4*AW-1:0] WrAdd = '0;
  logic [4*DW-1:0] WrData = '0;
  logic RdReq = 1'b0, RdSelC = 1'b0;
  logic [1:0] RdLane = '0;
  logic [AW-1:0] RdAdd = '0;
  logic RdGnt, RdValid, MemEn, MemWe, MemSelC;
  logic [DW-1:0] RdData, MemWData;
  logic [DW-1:0] MemRData = '0;
  logic [1:0] MemLane;
  logic [AW-1:0] MemAdd;
  logic OvfClr = 1'b0;
  logic [3:0] Overflow;
  logic [11:0] FifoLevel;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rx_frame_mem_arbiter #(.ADD_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .WrReq(WrReq), .WrSelC(WrSelC), .WrAdd(WrAdd), .WrData(WrData),
    .RdReq(RdReq), .RdLane(RdLane), .RdSelC(RdSelC), .RdAdd(RdAdd),
    .RdGnt(RdGnt), .RdValid(RdValid), .RdData(RdData),
    .MemEn(MemEn), .MemWe(MemWe), .MemLane(MemLane), .MemSelC(MemSelC), .MemAdd(MemAdd),
    .MemWData(MemWData), .MemRData(MemRData),
    .OvfClr(OvfClr), .Overflow(Overflow), .FifoLevel(FifoLevel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [19:0] mkey(input logic [1:0] l, input logic s, input logic [AW-1:0] a);
    return {l, s, a};
  endfunction

  function automatic logic [DW-1:0] dflt(input bit [19:0] k);
    return k[4:0] ^ 5'h15;
  endfunction

  // Memory environment: synchronous RAM, one-cycle read latency.
  logic [DW-1:0] ram [bit [19:0]];
  logic l_en = 1'b0, l_we = 1'b0;
  bit [19:0] l_key;
  logic [DW-1:0] l_wd;
  initial forever begin
    @(negedge clk);
    l_en = MemEn; l_we = MemWe; l_key = mkey(MemLane, MemSelC, MemAdd); l_wd = MemWData;
  end
  initial forever begin
    @(posedge clk);
    if (l_en) begin
      if (l_we) ram[l_key] = l_wd;
      else MemRData <= ram.exists(l_key) ? ram[l_key] : dflt(l_key);
    end
  end

  // Behavioural model: lane queues, rotating priority, expected memory op and read return.
  typedef struct packed { logic s; logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q [4][$];
  logic [DW-1:0] shadow [bit [19:0]];
  bit run = 0;
  int rr = 0, wl;
  bit any_full;
  ent_t me;
  bit [19:0] mk;
  logic [3:0] m_ovf = '0;
  logic m_en = 0, m_we = 0, m_selc = 0, m_rv = 0;
  logic [1:0] m_lane = '0;
  logic [AW-1:0] m_add = '0;
  logic [DW-1:0] m_wd = '0, m_rd = '0;

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      run = 0; rr = 0; m_ovf = '0; m_en = 0; m_we = 0; m_rv = 0; m_rd = '0;
    end else begin
      mk = mkey(m_lane, m_selc, m_add);
      m_rv = m_en && !m_we;
      if (m_rv) m_rd = shadow.exists(mk) ? shadow[mk] : dflt(mk);
      if (m_en && m_we) shadow[mk] = m_wd;
      any_full = 0;
      for (int i = 0; i < 4; i++) if (q[i].size() == DEPTH) any_full = 1;
      wl = -1;
      if (run && RdReq && !any_full) begin
        m_en = 1; m_we = 0; m_lane = RdLane; m_selc = RdSelC; m_add = RdAdd;
      end else begin
        if (run)
          for (int k = 0; k < 4; k++)
            if (wl < 0 && q[(rr + k) % 4].size() > 0) wl = (rr + k) % 4;
        if (wl >= 0) begin
          me = q[wl].pop_front();
          m_en = 1; m_we = 1; m_lane = 2'(wl); m_selc = me.s; m_add = me.a; m_wd = me.d;
          rr = (wl + 1) % 4;
        end else begin
          m_en = 0; m_we = 0;
        end
      end
      if (OvfClr) m_ovf = '0;
      for (int i = 0; i < 4; i++)
        if (WrReq[i]) begin
          if (q[i].size() < DEPTH) q[i].push_back({WrSelC[i], WrAdd[i*AW +: AW], WrData[i*DW +: DW]});
          else m_ovf[i] = 1'b1;
        end
      run = 1;
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  bit exp_gnt;
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      exp_gnt = run && RdReq;
      for (int i = 0; i < 4; i++) if (q[i].size() == DEPTH) exp_gnt = 0;
      chk("RdGnt", RdGnt, exp_gnt);
      chk("MemEn", MemEn, m_en);
      chk("MemWe", MemWe, m_we);
      if (m_en) begin
        chk("MemLane", MemLane, m_lane);
        chk("MemSelC", MemSelC, m_selc);
        chk("MemAdd", MemAdd, m_add);
        if (m_we) chk("MemWData", MemWData, m_wd);
      end
      chk("RdValid", RdValid, m_rv);
      if (m_rv) chk("RdData", RdData, m_rd);
      chk("Overflow", Overflow, m_ovf);
      for (int i = 0; i < 4; i++) chk($sformatf("FifoLevel%0d", i), FifoLevel[i*3 +: 3], q[i].size());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int lane, input logic s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    WrReq[lane] = 1'b1; WrSelC[lane] = s; WrAdd[lane*AW +: AW] = a; WrData[lane*DW +: DW] = d;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    cyc(); cyc();

    // All four lanes at once from pointer 0: served 0,1,2,3.
    cyc();
    for (int l = 0; l < 4; l++) set_wr(l, 1'(l), 17'h00400 + 17'(l), 5'(l + 3));
    cyc(); WrReq = '0;
    @(negedge clk); chk("rr_levels", FifoLevel, 12'b001_001_001_001);
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      chk("rr_we", MemWe, 1);
      chk("rr_lane", MemLane, l);
    end
    repeat (3) cyc();

    // Read beats pending writes on lanes 0 and 3; pointer is back at 0.
    cyc(); set_wr(0, 0, 17'h00010, 5'h03); set_wr(3, 1, 17'h00020, 5'h1C);
    cyc(); WrReq = '0; RdReq = 1; RdLane = 2'd1; RdSelC = 0; RdAdd = 17'h095FF;
    @(negedge clk); chk("rd_gnt", RdGnt, 1);
    cyc(); RdReq = 0;
    @(negedge clk);
    chk("rd_op_en", MemEn, 1); chk("rd_op_we", MemWe, 0);
    chk("rd_op_lane", MemLane, 1); chk("rd_op_add", MemAdd, 17'h095FF);
    @(negedge clk);
    chk("rd_valid", RdValid, 1); chk("rd_data", RdData, 5'h0A);
    chk("wr_after_rd_lane", MemLane, 0); chk("wr_after_rd_we", MemWe, 1);
    @(negedge clk); chk("wr_lane3", MemLane, 3);
    repeat (3) cyc();

    // Single write on lane 2 reaches memory two cycles later.
    cyc(); set_wr(2, 1, 17'h00123, 5'h1A);
    cyc(); WrReq = '0;
    @(negedge clk);
    @(negedge clk);
    chk("w2_en", MemEn, 1); chk("w2_we", MemWe, 1); chk("w2_lane", MemLane, 2);
    chk("w2_selc", MemSelC, 1); chk("w2_add", MemAdd, 17'h00123); chk("w2_data", MemWData, 5'h1A);
    repeat (3) cyc();

    // Lane 0 fills under a held read; lane 3 takes the urgent slot so beat 5 is dropped.
    cyc(); RdReq = 1; RdLane = 2'd2; RdSelC = 1; RdAdd = 17'h00123;
    set_wr(0, 0, 17'h00101, 5'h01); set_wr(3, 0, 17'h00033, 5'h0F);
    for (int b = 2; b <= 4; b++) begin
      cyc(); WrReq = '0; set_wr(0, 0, 17'h00100 + 17'(b), 5'(b));
    end
    cyc(); WrReq = '0; set_wr(0, 0, 17'h00105, 5'h05);
    @(negedge clk); chk("full_gnt", RdGnt, 0); chk("full_lvl0", FifoLevel[2:0], 4);
    cyc(); WrReq = '0;
    @(negedge clk); chk("ovf_set", Overflow, 4'b0001);
    repeat (2) cyc();
    RdReq = 0;
    repeat (8) cyc();
    OvfClr = 1;
    cyc(); OvfClr = 0;
    @(negedge clk); chk("ovf_clr", Overflow, 4'b0000);

    // Lane 3 full: push and pop together keep level 4 without overflow.
    cyc(); RdReq = 1; RdLane = 2'd0; RdSelC = 0; RdAdd = 17'h00007;
    set_wr(3, 0, 17'h00200, 5'h10);
    for (int b = 1; b <= 4; b++) begin
      cyc(); WrReq = '0; set_wr(3, 0, 17'h00200 + 17'(b), 5'(16 + b));
    end
    @(negedge clk); chk("pp_gnt", RdGnt, 0); chk("pp_lvl_before", FifoLevel[11:9], 4);
    cyc(); WrReq = '0;
    @(negedge clk); chk("pp_lvl_after", FifoLevel[11:9], 4); chk("pp_ovf", Overflow, 4'b0000);
    cyc(); RdReq = 0;
    repeat (8) cyc();

    // Reset with levels {4,2,0,1} and a read in flight.
    cyc(); RdReq = 1; RdLane = 2'd3; RdSelC = 1; RdAdd = 17'h1ABCD;
    set_wr(3, 1, 17'h00300, 5'h11); set_wr(2, 0, 17'h00301, 5'h12); set_wr(0, 1, 17'h00302, 5'h13);
    cyc(); WrReq = '0; set_wr(3, 1, 17'h00303, 5'h14); set_wr(2, 0, 17'h00304, 5'h15);
    cyc(); WrReq = '0; set_wr(3, 1, 17'h00305, 5'h16);
    cyc(); WrReq = '0; set_wr(3, 1, 17'h00306, 5'h17);
    cyc(); WrReq = '0;
    chk("pre_rst_levels", FifoLevel, 12'b100_010_000_001);
    #1 rstn = 0; RdReq = 0;
    #1;
    chk("rst_gnt", RdGnt, 0); chk("rst_valid", RdValid, 0); chk("rst_rdata", RdData, 0);
    chk("rst_en", MemEn, 0); chk("rst_we", MemWe, 0); chk("rst_lane", MemLane, 0);
    chk("rst_selc", MemSelC, 0); chk("rst_add", MemAdd, 0); chk("rst_wdata", MemWData, 0);
    chk("rst_ovf", Overflow, 0); chk("rst_level", FifoLevel, 0);
    repeat (2) @(posedge clk);
    #1 RdReq = 1; RdLane = 2'd0; RdSelC = 0; RdAdd = 17'h00005; rstn = 1;
    @(negedge clk); chk("rel_no_gnt", RdGnt, 0);
    @(negedge clk); chk("rel_gnt", RdGnt, 1); chk("rel_no_op", MemEn, 0);
    cyc(); RdReq = 0;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
